// File: rtl/ss_seq_pkg.sv
// ss_seq_pkg: state encoding and shared constants for the save-state sequencer
package ss_seq_pkg;
  typedef enum logic [2:0] {IDLE, SAVE, CHK, FETCH, WRITE, FIN} state_t;
  localparam int MAP_IDX_DEF = 127;
  localparam logic [7:0] UNMAPPED = 8'hFF;
endpackage

// File: rtl/ss_buf.sv
// ss_buf: 128x8 snapshot buffer; sequencer read/write port, host read port, synchronous reads
module ss_buf (
  input  logic       clk,
  input  logic [6:0] a_addr,
  input  logic       a_we,
  input  logic [7:0] a_wdat,
  output logic [7:0] a_rdat,
  input  logic [6:0] b_addr,
  output logic [7:0] b_rdat
);
  logic [7:0] mem [128];
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdat;
    a_rdat <= mem[a_addr];
    b_rdat <= mem[b_addr];
  end
endmodule

// File: rtl/ss_seq.sv
// ss_seq: mapper save-state capture/restore sequencer over a 128x8 snapshot buffer
// SS_SKIP_FF_EN: restore skips buffer entries holding 8'hFF without waiting for a tick
module ss_seq
  import ss_seq_pkg::*;
#(
  parameter int N_REGS       = 32,
  parameter int MAP_IDX_ADDR = MAP_IDX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_save,
  input  logic       cmd_load,
  input  logic       m2_tick,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic [6:0] hb_addr,
  input  logic       hb_we,
  input  logic [7:0] hb_wdat,
  output logic [7:0] hb_rdat
);
  localparam logic [6:0] LAST = 7'(N_REGS - 1);
  localparam logic [6:0] MIDX = 7'(MAP_IDX_ADDR);
  state_t state;
  logic [6:0] addr, a_addr;
  logic [7:0] a_rdat;
  logic primed, a_we, tk_chk, mism, skip, to_fin;
  assign busy    = state != IDLE;
  assign ss_addr = {1'b0, addr};
  assign tk_chk  = state == CHK && m2_tick && primed;
  assign mism    = ss_rdat != a_rdat;
`ifdef SS_SKIP_FF_EN
  assign skip = state == FETCH && a_rdat == UNMAPPED;
`else
  assign skip = 1'b0;
`endif
  assign a_we   = state == IDLE ? hb_we : state == SAVE && m2_tick;
  assign to_fin = (state == SAVE && m2_tick && addr == MIDX) || (tk_chk && mism) ||
                  (skip && addr == LAST) || (state == WRITE && m2_tick && addr == LAST);
  // Buffer address leads the state by one cycle so synchronous read data is ready on arrival
  always_comb
    a_addr = state == IDLE  ? (hb_we ? hb_addr : MIDX) :
             state == CHK   ? (tk_chk && !mism ? 7'd0 : MIDX) :
             state == WRITE ? (m2_tick ? addr + 7'd1 : addr) :
             state == FETCH ? addr + 7'd1 : addr;
  ss_buf u_buf (
    .clk    (clk),
    .a_addr (a_addr),
    .a_we   (a_we),
    .a_wdat (state == IDLE ? hb_wdat : ss_rdat),
    .a_rdat (a_rdat),
    .b_addr (hb_addr),
    .b_rdat (hb_rdat)
  );
  // primed guards CHK against stale read data when a host write shared the launch cycle
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      addr    <= '0;
      ss_act  <= 1'b0;
      ss_we   <= 1'b0;
      ss_wdat <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      primed  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_save || cmd_load) begin
          state  <= cmd_save ? SAVE : CHK;
          addr   <= cmd_save ? 7'd0 : MIDX;
          primed <= !hb_we;
          ss_act <= 1'b1;
          err    <= 1'b0;
        end
        SAVE: if (m2_tick) addr <= addr == LAST ? MIDX : addr + 7'd1;
        CHK: begin
          primed <= 1'b1;
          if (tk_chk && mism) err <= 1'b1;
          if (tk_chk) begin
            state <= FETCH;
            addr  <= '0;
          end
        end
        FETCH: begin
          ss_wdat <= a_rdat;
          if (skip) addr <= addr + 7'd1;
          else begin
            state <= WRITE;
            ss_we <= 1'b1;
          end
        end
        WRITE: if (m2_tick) begin
          state <= FETCH;
          ss_we <= 1'b0;
          addr  <= addr + 7'd1;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (to_fin) begin
        state  <= FIN;
        ss_act <= 1'b0;
        ss_we  <= 1'b0;
        done   <= 1'b1;
      end
    end
endmodule

// File: tb/tb_ss_seq.sv
// tb_ss_seq: directed self-checking bench for ss_seq with an addr^8'h5A mapper model
`timescale 1ns/1ps
module tb_ss_seq;
  logic clk = 0, rst = 1, cmd_save = 0, cmd_load = 0, m2_tick = 0, hb_we = 0, clr = 0;
  logic ss_act, ss_we, busy, done, err;
  logic [7:0] ss_addr, ss_wdat, ss_rdat, hb_rdat;
  logic [7:0] hb_wdat = 0, map_idx = 8'h25;
  logic [6:0] hb_addr = 0;
  int vecs = 0, errs = 0, ticks = 0, we_cyc = 0;
  logic [7:0] wr_addr[$], wr_dat[$];
  typedef struct {
    logic [6:0] addr;
    logic       we;
    logic [7:0] wdat;
    logic       chk;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[10];

  ss_seq dut (
    .clk(clk), .rst(rst), .cmd_save(cmd_save), .cmd_load(cmd_load), .m2_tick(m2_tick),
    .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
    .busy(busy), .done(done), .err(err),
    .hb_addr(hb_addr), .hb_we(hb_we), .hb_wdat(hb_wdat), .hb_rdat(hb_rdat)
  );

  always #5 clk = ~clk;
  always_comb ss_rdat = ss_addr == 8'd127 ? map_idx : ss_addr ^ 8'h5A;

  initial begin
    int t = 0;
    forever begin
      @(negedge clk);
      t++;
      m2_tick = t % 4 == 0;
    end
  end

  initial forever begin
    @(posedge clk);
    if (clr) begin
      ticks = 0;
      we_cyc = 0;
      wr_addr.delete();
      wr_dat.delete();
    end else begin
      if (ss_we) we_cyc++;
      if (m2_tick && ss_act) ticks++;
      if (m2_tick && ss_we) begin
        wr_addr.push_back(ss_addr);
        wr_dat.push_back(ss_wdat);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_logs();
    clr = 1;
    @(negedge clk);
    clr = 0;
  endtask

  task automatic pulse(input logic s, input logic l);
    cmd_save = s;
    cmd_load = l;
    @(negedge clk);
    cmd_save = 0;
    cmd_load = 0;
  endtask

  task automatic hb_write(input logic [6:0] a, input logic [7:0] d);
    hb_addr = a;
    hb_wdat = d;
    hb_we = 1;
    @(negedge clk);
    hb_we = 0;
  endtask

  task automatic hb_rd_chk(input string nm, input logic [6:0] a, input logic [7:0] exp);
    hb_addr = a;
    @(negedge clk);
    chk(nm, 32'(hb_rdat), 32'(exp));
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, 32'(done), 1);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(done), 0);
    chk({nm, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    logic [7:0] ea[$], ed[$];
    int n;
    tbl = '{
      '{7'd0,   1'b0, 8'h00, 1'b1, 8'h5A},
      '{7'd31,  1'b0, 8'h00, 1'b1, 8'h45},
      '{7'd127, 1'b0, 8'h00, 1'b1, 8'h25},
      '{7'd5,   1'b0, 8'h00, 1'b1, 8'h5F},
      '{7'd50,  1'b1, 8'h11, 1'b0, 8'h00},
      '{7'd50,  1'b0, 8'h00, 1'b1, 8'h11},
      '{7'd40,  1'b1, 8'hC3, 1'b0, 8'h00},
      '{7'd40,  1'b1, 8'h3C, 1'b1, 8'hC3},
      '{7'd40,  1'b0, 8'h00, 1'b1, 8'h3C},
      '{7'd17,  1'b0, 8'h00, 1'b1, 8'h4B}
    };
    cyc(3);
    rst = 0;
    chk("rst_act", 32'(ss_act), 0);
    chk("rst_we", 32'(ss_we), 0);
    chk("rst_addr", 32'(ss_addr), 0);
    chk("rst_wdat", 32'(ss_wdat), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);

    // capture: 32 registers plus the mapper index
    clr_logs();
    pulse(1, 0);
    chk("save_busy", 32'(busy), 1);
    chk("save_addr0", 32'(ss_addr), 0);
    wait_done("save", 600);
    chk("save_ticks", 32'(ticks), 33);
    chk("save_err", 32'(err), 0);
    for (int i = 0; i < 32; i++) hb_rd_chk($sformatf("save_buf%0d", i), 7'(i), 8'(i) ^ 8'h5A);
    hb_rd_chk("save_idx", 7'd127, 8'h25);

    foreach (tbl[k]) begin
      hb_addr = tbl[k].addr;
      hb_we = tbl[k].we;
      hb_wdat = tbl[k].wdat;
      @(negedge clk);
      hb_we = 0;
      if (tbl[k].chk) chk($sformatf("tbl%0d", k), 32'(hb_rdat), 32'(tbl[k].exp));
    end

    // restore with matching index
    for (int i = 0; i < 32; i++) hb_write(7'(i), 8'(i));
    hb_write(7'd127, 8'h4B);
    map_idx = 8'h4B;
    clr_logs();
    pulse(0, 1);
    chk("load_chk_addr", 32'(ss_addr), 127);
    wait_done("load", 800);
    chk("load_err", 32'(err), 0);
    chk("load_nwr", wr_addr.size(), 32);
    for (int i = 0; i < 32 && i < wr_addr.size(); i++) begin
      chk($sformatf("load_addr%0d", i), 32'(wr_addr[i]), i);
      chk($sformatf("load_dat%0d", i), 32'(wr_dat[i]), i);
    end

    // restore with mismatching index
    hb_write(7'd127, 8'h10);
    clr_logs();
    pulse(0, 1);
    wait_done("mism", 200);
    chk("mism_err", 32'(err), 1);
    chk("mism_we_cyc", 32'(we_cyc), 0);
    cyc(3);
    chk("mism_err_sticky", 32'(err), 1);

    // reset in the middle of a restore
    hb_write(7'd127, 8'h4B);
    clr_logs();
    pulse(0, 1);
    chk("rst_mid_err_clr", 32'(err), 0);
    n = 0;
    while (wr_addr.size() < 5 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_5wr", wr_addr.size(), 5);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_act", 32'(ss_act), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_we", 32'(ss_we), 0);
    chk("rst_mid_addr", 32'(ss_addr), 0);
    rst = 0;
    hb_rd_chk("rst_buf0", 7'd0, 8'd0);
    hb_rd_chk("rst_buf4", 7'd4, 8'd4);
    hb_rd_chk("rst_buf31", 7'd31, 8'd31);
    hb_rd_chk("rst_buf127", 7'd127, 8'h4B);

    // simultaneous commands, then commands and host writes while busy
    map_idx = 8'h25;
    clr_logs();
    pulse(1, 1);
    chk("both_addr", 32'(ss_addr), 0);
    chk("both_act", 32'(ss_act), 1);
    cyc(2);
    hb_addr = 7'd50;
    hb_wdat = 8'hEE;
    hb_we = 1;
    pulse(0, 1);
    hb_we = 0;
    wait_done("both", 600);
    chk("both_ticks", 32'(ticks), 33);
    chk("both_we_cyc", 32'(we_cyc), 0);
    cyc(6);
    chk("both_no_load", 32'(busy), 0);
    hb_rd_chk("both_hb_drop", 7'd50, 8'h11);
    hb_rd_chk("both_buf3", 7'd3, 8'h59);
    hb_rd_chk("both_buf127", 7'd127, 8'h25);

    // 8'hFF entries: skipped with SS_SKIP_FF_EN, written as-is otherwise
    for (int i = 0; i < 32; i++) hb_write(7'(i), (i == 3 || i == 7) ? 8'hFF : 8'(i));
    hb_write(7'd127, 8'h4B);
    map_idx = 8'h4B;
    for (int i = 0; i < 32; i++) begin
`ifdef SS_SKIP_FF_EN
      if (i == 3 || i == 7) continue;
`endif
      ea.push_back(8'(i));
      ed.push_back((i == 3 || i == 7) ? 8'hFF : 8'(i));
    end
    clr_logs();
    pulse(0, 1);
    wait_done("ff", 800);
    chk("ff_nwr", wr_addr.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wr_addr.size(); i++) begin
      chk($sformatf("ff_addr%0d", i), 32'(wr_addr[i]), 32'(ea[i]));
      chk($sformatf("ff_dat%0d", i), 32'(wr_dat[i]), 32'(ed[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ss_seq.md
SS_SEQ -- requirements
Module: ss_seq

Interface
REQ-001 SHALL have parameter N_REGS, default 32, number of mapper save-state addresses captured (0..N_REGS-1), range 1..127.
REQ-002 SHALL have parameter MAP_IDX_ADDR, default 127, save-state address holding the mapper index.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cmd_save  in  1  one-cycle pulse; start a capture of mapper registers into the buffer.
REQ-006 cmd_load  in  1  one-cycle pulse; start a restore of mapper registers from the buffer.
REQ-007 m2_tick  in  1  one-cycle pulse marking the mapper's latch edge; one save-state access completes per accepted tick.
REQ-008 ss_act  out  1  save-state mode active towards the mapper.
REQ-009 ss_we  out  1  save-state write strobe.
REQ-010 ss_addr  out  8  save-state register address.
REQ-011 ss_wdat  out  8  restore data, driven onto the mapper's data input.
REQ-012 ss_rdat  in  8  mapper save-state read data.
REQ-013 busy  out  1  sequence in progress.
REQ-014 done  out  1  one-cycle pulse at the end of a sequence.
REQ-015 err  out  1  sticky; mapper index mismatch on load; cleared by the next accepted command or by rst.
REQ-016 hb_addr  in  7 / hb_we  in  1 / hb_wdat  in  8 / hb_rdat  out  8  host port to the 128x8 snapshot buffer.

Function
REQ-017 SHALL use states IDLE, SAVE, CHK, FETCH, WRITE, FIN.
REQ-018 IDLE: cmd_save -> SAVE at addr 0; cmd_load -> CHK; both in the same cycle -> save wins; commands while busy are ignored.
REQ-019 SAVE: ss_act=1, ss_we=0, ss_addr=current addr; on m2_tick, buf[addr]<=ss_rdat and advance through 0..N_REGS-1, then MAP_IDX_ADDR, then FIN.
REQ-020 CHK: ss_addr=MAP_IDX_ADDR, read only; on m2_tick, ss_rdat!=buf[MAP_IDX_ADDR] -> err=1 and FIN, no writes issued; equal -> FETCH at addr 0.
REQ-021 FETCH: lasts exactly 1 cycle, ss_we=0, reads buf[addr] into the ss_wdat register; an m2_tick during FETCH is ignored.
REQ-022 WRITE: ss_we=1, ss_addr=addr, ss_wdat stable; on m2_tick, advance to the next addr (FETCH) or, after N_REGS-1, to FIN; MAP_IDX_ADDR is never written.
REQ-023 FIN: ss_act=0, ss_we=0, done=1 for one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-024 ss_addr, ss_we and ss_act SHALL be registered, change only on clk edges, and never change in the cycle an m2_tick is accepted.
REQ-025 Host port: hb_rdat=buf[hb_addr] with 1-cycle latency in all states; hb_we is honoured only when busy=0 and is silently dropped otherwise.
REQ-026 Address counter SHALL be 7 bits; ss_addr[7]=0 always.

Reset
REQ-027 rst SHALL force IDLE, ss_act=0, ss_we=0, ss_addr=0, ss_wdat=0, busy=0, done=0, err=0 on the next edge, including mid-sequence.
REQ-028 Buffer contents are not cleared by rst.

Configuration
REQ-029 Macro SS_SKIP_FF_EN defined: in FETCH, buf[addr]==8'hFF skips WRITE and advances directly to the next FETCH/FIN without waiting for m2_tick.
REQ-030 Macro SS_SKIP_FF_EN undefined: every addr 0..N_REGS-1 is written regardless of value.

Structure
REQ-031 Shared package SHALL hold the state enum, the default MAP_IDX_ADDR constant and the 8'hFF unmapped-value constant.
REQ-032 Snapshot buffer SHALL be the sub-module ss_buf (128x8, one read/write port for the sequencer, one read port for the host, synchronous read).

Verification
REQ-033 Mapper model returns addr^8'h5A; cmd_save, tick every 4 clk -> buf[0..31] and buf[127] match, done after 33 ticks, err=0.
REQ-034 Host writes buf[127]=8'h4B, buf[0..31]=i; model index 8'h4B; cmd_load -> 32 writes, addresses 0..31 in order with data i, none to 127.
REQ-035 buf[127]=8'h10, model index 8'h4B; cmd_load -> err=1, done pulse, zero ss_we cycles.
REQ-036 rst asserted after the 5th write tick of a load -> ss_act=0 next cycle, busy=0, buffer unchanged.
REQ-037 cmd_save and cmd_load in the same cycle, then cmd_load while busy -> save only; host hb_we=1 while busy has no effect.
REQ-038 With SS_SKIP_FF_EN, buf[3]=buf[7]=8'hFF -> 30 writes, addresses 3 and 7 absent.
